ts_ref_counter: RTL and testbench
=================================

# ts_ref_counter

Parametrised timestamp reference counter, and the next generation of the single-channel 64-bit edge counter. It counts rising edges of an asynchronous external reference clock in the `sampling_clk` domain. The count is held as `NSEG = WIDTH/SEG_WIDTH` segments, and carries are pipelined one segment per cycle so that wide counts close timing. It provides a coherent latched reference with a valid strobe, a carry-overrun error and an optional lost-clock watchdog, and feeds the trigger timestamping logic.

## Interface
- `WIDTH`, 64: total count width; must be a multiple of `SEG_WIDTH`.
- `SEG_WIDTH`, 32: width of each carry-pipelined segment.
- `TIMEOUT`, 1024: sampling cycles without an edge before `clk_lost` asserts (watchdog builds only).
- `sampling_clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous, active-high; clears every register.
- `clk_in_async` in 1: external reference clock, asynchronous.
- `ref_reset_async` in 1: asynchronous count-reset request; acts on its synchronised falling edge.
- `ref` out WIDTH: count latched at the last edge.
- `ref_valid` out 1: one-cycle pulse when `ref` updates.
- `err_overrun` out 1: sticky flag; an edge arrived while a carry was still rippling.
- `clk_lost` out 1: watchdog flag; constant 0 when the watchdog is compiled out.

## Operation
- Both async inputs pass through the codebase `sync` block.
  - `edge` is the rising pulse of `clk_in_async`.
  - `clr` is the falling pulse of `ref_reset_async`.
- Edge handling, when `edge` and not `clr`:
  - `ref` takes the pre-increment count, all segments concatenated with segment 0 in the LSBs.
  - segment 0 increments.
  - if segment 0 was all-ones, `carry[1]` is set.
- Carry ripple: in any cycle where `carry[k]` is set, segment k increments and `carry[k]` clears. If segment k was all-ones and k < NSEG-1, `carry[k+1]` is set.
- Wrap-around: a carry out of the top segment is discarded, so the count wraps all-ones to 0 with no flag.
- Overrun: an edge that occurs while any `carry[k]` is set sets `err_overrun`.
  - The count stays correct; the pending ripple continues and is not lost.
  - The captured `ref` for that edge may be incoherent.
  - `ref_valid` still pulses.
- Count reset (`clr`):
  - clears all segments, all carries, `err_overrun` and the watchdog counter.
  - `ref` holds its value.
  - `clr` and `edge` in the same cycle: `clr` wins and the edge is dropped, with no `ref_valid`.
- Coherency rule for the source: edges must be at least NSEG sampling cycles apart. At that spacing `err_overrun` never sets.

## Timing
- Reset values:
  - `ref` = 0, `ref_valid` = 0, `err_overrun` = 0, `clk_lost` = 0.
  - all segments and carries 0.
- Input latency: the `edge` and `clr` pulses come from `sync` with its standard latency. All following latencies are counted from the cycle the pulse is high.
- `ref` and `ref_valid` are registered and appear 1 cycle after `edge`.
- Carry into segment k completes k cycles after the `edge` that caused it.
- `clr` takes effect on the next clock edge; the first edge after it yields `ref` = 0.
- `rst` asserted mid-ripple: all state clears immediately, independent of the clock.

## Configuration
- `TS_REF_WATCHDOG_EN` defined:
  - a counter of `$clog2(TIMEOUT+1)` bits counts sampling cycles since the last `edge` and saturates at `TIMEOUT`.
  - `clk_lost` = 1 while the counter equals `TIMEOUT`.
  - `edge` or `clr` zeroes the counter and drops `clk_lost` on the next cycle.
- `TS_REF_WATCHDOG_EN` undefined: the counter is absent, `clk_lost` is tied to 0 and `TIMEOUT` is ignored.

## Structure
- Package `ts_ref_pkg`: holds the default `WIDTH`, `SEG_WIDTH` and `TIMEOUT` constants, plus a function computing NSEG and checking the width divisibility rule at elaboration.
- Sub-module `ts_ref_seg`: one segment register with increment-on-enable, a clear input, and `carry_out = en & all_ones`. It is instantiated NSEG times via a generate block.
- Two `sync` instances handle the async inputs.

## Test plan
- Plain counting: WIDTH=16, SEG_WIDTH=4; 5 edges spaced 8 cycles apart. Required: `ref` reads 0,1,2,3,4 with 5 `ref_valid` pulses.
- Carry ripple: preload the count to 0x00FF via edges, then 1 edge. Required: `ref`=0x00FF; 2 cycles later the internal count is 0x0100; the next edge gives `ref`=0x0100.
- Wrap: the count reaches 0xFFFF, then 2 edges spaced 8 cycles apart. Required: `ref`=0xFFFF, then `ref`=0x0000; no flag is set.
- Overrun: from count 0x0FFF, 2 edges 1 cycle apart. Required: `err_overrun`=1; after settling, the count is 0x1001. A following `clr` clears `err_overrun`.
- `clr` collides with an edge: `clr` and `edge` land in the same cycle. Required: no `ref_valid`; the count is 0; `ref` is unchanged; the next edge gives `ref`=0.
- Watchdog (with `TS_REF_WATCHDOG_EN`, TIMEOUT=20): stop the clock. Required: `clk_lost`=1 exactly 20 cycles after the last edge, and 0 one cycle after the next edge. Without the macro, `clk_lost` stays 0.

Source files
------------

// File: rtl/ts_ref_pkg.sv
// Shared constants and elaboration helpers for the ts_ref_counter timestamp reference counter.
package ts_ref_pkg;

  localparam int TS_REF_WIDTH     = 64;
  localparam int TS_REF_SEG_WIDTH = 32;
  localparam int TS_REF_TIMEOUT   = 1024;

  // Returns the segment count, or 0 when the width is not an exact multiple
  // of the segment width; the top refuses to elaborate on 0.
  function automatic int ts_ref_nseg(input int width, input int seg_width);
    if (seg_width <= 0 || width <= 0) return 0;
    if ((width % seg_width) != 0) return 0;
    return width / seg_width;
  endfunction

endpackage

// File: rtl/sync.sv
// Two-flop synchroniser with single-cycle rising or falling pulse output.
module sync #(
  parameter int STAGES    = 2,
  parameter bit FALL_EDGE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic pulse_o
);

  logic [STAGES-1:0] meta_q, meta_d;
  logic              prev_q, prev_d;

  if (STAGES < 2) begin : g_bad_stages
    $error("sync needs at least two stages");
  end

  always_comb begin
    meta_d = {meta_q[STAGES-2:0], async_i};
    prev_d = meta_q[STAGES-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      prev_q <= prev_d;
    end
  end

  assign pulse_o = FALL_EDGE ? (prev_q & ~meta_q[STAGES-1])
                             : (~prev_q & meta_q[STAGES-1]);

endmodule

// File: rtl/ts_ref_seg.sv
// One carry-pipelined count segment: clear has priority over increment.
module ts_ref_seg #(
  parameter int SEG_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [SEG_WIDTH-1:0] q_o,
  output logic                 carry_o
);

  localparam logic [SEG_WIDTH-1:0] ONE = SEG_WIDTH'(1);

  logic [SEG_WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = q_q + ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o     = q_q;
  assign carry_o = en_i & (&q_q);

endmodule

// File: rtl/ts_ref_counter.sv
// Segmented reference-clock edge counter with latched ref, overrun flag and
// optional lost-clock watchdog (enabled by defining TS_REF_WATCHDOG_EN).
module ts_ref_counter
  import ts_ref_pkg::*;
#(
  parameter int WIDTH     = TS_REF_WIDTH,
  parameter int SEG_WIDTH = TS_REF_SEG_WIDTH,
  parameter int TIMEOUT   = TS_REF_TIMEOUT
) (
  input  logic             sampling_clk,
  input  logic             rst,
  input  logic             clk_in_async,
  input  logic             ref_reset_async,
  output logic [WIDTH-1:0] ref_o,
  output logic             ref_valid,
  output logic             err_overrun,
  output logic             clk_lost
);

  localparam int NSEG = ts_ref_nseg(WIDTH, SEG_WIDTH);

  if (NSEG == 0) begin : g_bad_width
    $error("ts_ref_counter: WIDTH must be a positive multiple of SEG_WIDTH");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("ts_ref_counter: TIMEOUT must be at least 1");
  end

  logic edge_pulse, clr_pulse, take_edge;

  sync #(.FALL_EDGE(1'b0)) u_sync_clk (
    .clk_i   (sampling_clk),
    .rst_i   (rst),
    .async_i (clk_in_async),
    .pulse_o (edge_pulse)
  );

  sync #(.FALL_EDGE(1'b1)) u_sync_clr (
    .clk_i   (sampling_clk),
    .rst_i   (rst),
    .async_i (ref_reset_async),
    .pulse_o (clr_pulse)
  );

  // A count reset in the same cycle as an edge swallows the edge.
  assign take_edge = edge_pulse & ~clr_pulse;

  logic [SEG_WIDTH-1:0] seg_q [NSEG];
  logic [NSEG-1:0]      seg_en, seg_co;
  logic [NSEG-1:0]      carry_q, carry_d;
  logic [WIDTH-1:0]     count_w;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    assign seg_en[k] = (k == 0) ? take_edge : carry_q[k];

    ts_ref_seg #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
      .clk_i   (sampling_clk),
      .rst_i   (rst),
      .clr_i   (clr_pulse),
      .en_i    (seg_en[k]),
      .q_o     (seg_q[k]),
      .carry_o (seg_co[k])
    );

    assign count_w[k*SEG_WIDTH +: SEG_WIDTH] = seg_q[k];
  end

  logic [WIDTH-1:0] ref_q, ref_d;
  logic             ref_valid_q, ref_valid_d;
  logic             err_q, err_d;

  // Carry out of segment k feeds segment k+1 next cycle; the shift drops the
  // top segment's carry, giving a silent wrap.
  always_comb begin
    ref_d       = ref_q;
    ref_valid_d = take_edge;
    err_d       = err_q;
    carry_d     = '0;
    if (clr_pulse) begin
      err_d = 1'b0;
    end else begin
      carry_d = seg_co << 1;
      if (take_edge) begin
        ref_d = count_w;
        if (|carry_q) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sampling_clk or posedge rst) begin
    if (rst) begin
      ref_q       <= '0;
      ref_valid_q <= 1'b0;
      err_q       <= 1'b0;
      carry_q     <= '0;
    end else begin
      ref_q       <= ref_d;
      ref_valid_q <= ref_valid_d;
      err_q       <= err_d;
      carry_q     <= carry_d;
    end
  end

  assign ref_o       = ref_q;
  assign ref_valid   = ref_valid_q;
  assign err_overrun = err_q;

`ifdef TS_REF_WATCHDOG_EN
  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Saturating count of sampling cycles since the last edge or count reset.
  always_comb begin
    wd_d = wd_q;
    if (edge_pulse | clr_pulse) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + WD_ONE;
    end
  end

  always_ff @(posedge sampling_clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign clk_lost = (wd_q == WD_MAX);
`else
  assign clk_lost = 1'b0;
`endif

endmodule

// File: tb/tb_ts_ref_counter.sv
// Randomised and directed bench for ts_ref_counter against a count-history model.
module tb_ts_ref_counter;

  localparam int W    = 12;
  localparam int S    = 4;
  localparam int NS   = W / S;
  localparam int TO   = 20;
  localparam int MAXC = 40000;
  localparam int MASK = (1 << W) - 1;
  localparam int SMSK = (1 << S) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clk_in = 1'b0;
  logic         rr = 1'b0;
  logic [W-1:0] ref_o;
  logic         ref_valid, err_overrun, clk_lost;

  ts_ref_counter #(.WIDTH(W), .SEG_WIDTH(S), .TIMEOUT(TO)) dut (
    .sampling_clk    (clk),
    .rst             (rst),
    .clk_in_async    (clk_in),
    .ref_reset_async (rr),
    .ref_o           (ref_o),
    .ref_valid       (ref_valid),
    .err_overrun     (err_overrun),
    .clk_lost        (clk_lost)
  );

  always #5 clk = ~clk;

  // Model: the true count after every sampling edge n, since the last count
  // reset. Segment k of the visible count lags the true count by k cycles.
  bit hin [MAXC];
  bit hrr [MAXC];
  int cnt_at [MAXC];
  int n = 0;
  int last_clr = 0;
  int exp_ref = 0;
  bit exp_vld = 1'b0, exp_err = 1'b0, exp_lost = 1'b0;
  int wd = 0;
  bit ed, cl;

  function automatic bit hb_in(input int i);
    return (i >= 0) ? hin[i] : 1'b0;
  endfunction

  function automatic bit hb_rr(input int i);
    return (i >= 0) ? hrr[i] : 1'b0;
  endfunction

  function automatic int cnt(input int i);
    if (i < 0 || i < last_clr) return 0;
    return cnt_at[i];
  endfunction

  function automatic int visible(input int t);
    int v = 0;
    for (int k = 0; k < NS; k++)
      v |= ((cnt(t - k) >> (k * S)) & SMSK) << (k * S);
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; last_clr = 0; exp_ref = 0; exp_vld = 0; exp_err = 0; wd = 0; exp_lost = 0;
    end else if (n < MAXC) begin
      hin[n] = clk_in;
      hrr[n] = rr;
      ed = hb_in(n - 2) & ~hb_in(n - 3);
      cl = ~hb_rr(n - 2) & hb_rr(n - 3);
      exp_vld = 1'b0;
      if (cl) begin
        cnt_at[n] = 0;
        last_clr  = n;
        exp_err   = 1'b0;
      end else if (ed) begin
        exp_ref = visible(n - 1);
        exp_vld = 1'b1;
        if (visible(n - 1) != cnt(n - 1)) exp_err = 1'b1;
        cnt_at[n] = (cnt(n - 1) + 1) & MASK;
      end else begin
        cnt_at[n] = cnt(n - 1);
      end
`ifdef TS_REF_WATCHDOG_EN
      if (ed || cl) wd = 0;
      else if (wd < TO) wd++;
      exp_lost = (wd == TO);
`else
      exp_lost = 1'b0;
`endif
      n++;
    end
  end

  int checks = 0;
  int fails = 0;
  int lit [64];
  int lit_wr = 0;
  int lit_rd = 0;
  bit end_req = 1'b0;
  bit done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input int expv);
    checks++;
    if (act !== 32'(expv)) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, n, act, expv);
    end
  endtask

  always @(negedge clk) begin
    chk("ref", 32'(ref_o), exp_ref);
    chk("ref_valid", 32'(ref_valid), int'(exp_vld));
    chk("err_overrun", 32'(err_overrun), int'(exp_err));
    chk("clk_lost", 32'(clk_lost), int'(exp_lost));
    if (ref_valid === 1'b1 && lit_rd < lit_wr) begin
      chk("lit_ref_dut", 32'(ref_o), lit[lit_rd]);
      chk("lit_ref_model", 32'(exp_ref), lit[lit_rd]);
      lit_rd++;
    end
    if (end_req && !done) begin
      chk("lit_all_seen", 32'(lit_rd), lit_wr);
      done = 1'b1;
    end
  end

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    clk_in = 1'b1;
    repeat (hi) @(negedge clk);
    clk_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic push(input int v);
    lit[lit_wr] = v;
    lit_wr++;
  endtask

  task automatic do_clr();
    rr = 1'b1;
    idle(3);
    rr = 1'b0;
    idle(5);
  endtask

  task automatic edges(input int num);
    for (int i = 0; i < num; i++) pulse(1, 2);
    idle(4);
  endtask

  initial begin
    #1 rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(4);

    // plain counting, 8 cycles apart
    for (int i = 0; i < 5; i++) begin
      push(i);
      pulse(1, 7);
    end

    // carry ripple through segment 1
    edges(250);
    push(12'h0FF); pulse(1, 6);
    push(12'h100); pulse(1, 6);

    // wrap-around at full scale
    edges(12'hFFF - 12'h101);
    push(12'hFFF); pulse(1, 7);
    push(12'h000); pulse(1, 7);

    // overrun: back-to-back edges while the carry ripples
    do_clr();
    edges(255);
    pulse(1, 1);
    pulse(1, 8);
    push(12'h101); pulse(1, 6);
    do_clr();

    // clr colliding with an edge
    edges(3);
    rr = 1'b1;
    idle(3);
    rr = 1'b0;
    clk_in = 1'b1;
    idle(1);
    clk_in = 1'b0;
    idle(8);
    push(12'h000); pulse(1, 6);

    // asynchronous reset in the middle of a ripple
    edges(254);
    clk_in = 1'b1;
    @(negedge clk);
    clk_in = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(4);
    push(12'h000); pulse(1, 6);

    // watchdog: clock stops, then resumes
    idle(30);
    pulse(1, 30);
    pulse(1, 6);

    // randomised edges, spacing and count resets
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        rr = 1'b1;
        idle($urandom_range(1, 3));
        rr = 1'b0;
        if ($urandom_range(0, 1) == 1) clk_in = 1'b1;
        idle(1);
        clk_in = 1'b0;
        idle($urandom_range(1, 4));
      end else if (r == 1) begin
        idle($urandom_range(10, 30));
      end else begin
        pulse($urandom_range(1, 2), $urandom_range(1, 6));
      end
    end

    idle(8);
    end_req = 1'b1;
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
